// File: rtl/flash_seq_pkg.sv
// Shared state encoding and pattern constants for the lag-measurement flash sequencer.
package flash_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_DARK = 2'd2,
    ST_LIT  = 2'd3
  } state_t;

  localparam logic [2:0]  MODE_SINGLE = 3'b011;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;

endpackage

// File: rtl/flash_sequencer_vs_edge_det.sv
// Frame-start detector: normalises VS polarity and emits a registered one-cycle pulse
// one cycle after the active VS edge.
module vs_edge_det (
  input  logic I_pxl_clk,
  input  logic I_rst_n,
  input  logic I_vs,
  input  logic I_vs_pol,
  output logic vs_act_d,
  output logic fs
);

  logic vs_act;

  assign vs_act = I_vs ^ ~I_vs_pol;

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_act_d <= 1'b0;
      fs       <= 1'b0;
    end else begin
      vs_act_d <= vs_act;
      fs       <= vs_act & ~vs_act_d;
    end
  end

endmodule

// File: rtl/flash_sequencer.sv
// Frame-synchronous dark/lit flash controller driving the test-pattern generator; all
// pattern changes land on frame start so no frame is torn.
//
// state | meaning
// IDLE  | generator shows I_idle_mode, sequence stopped
// ARM   | enabled, waiting for the first frame start to latch configuration
// DARK  | black single-colour frames, counting down dark_n frames
// LIT   | lit single-colour frames, counting down lit_n frames
module flash_sequencer
  import flash_seq_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             I_pxl_clk,
  input  logic             I_rst_n,
  input  logic             I_vs,
  input  logic             I_vs_pol,
  input  logic             I_enable,
  input  logic [CNT_W-1:0] I_dark_frames,
  input  logic [CNT_W-1:0] I_lit_frames,
  input  logic [7:0]       I_lit_r,
  input  logic [7:0]       I_lit_g,
  input  logic [7:0]       I_lit_b,
  input  logic [2:0]       I_idle_mode,
  output logic [2:0]       O_mode,
  output logic [7:0]       O_single_r,
  output logic [7:0]       O_single_g,
  output logic [7:0]       O_single_b,
  output logic             O_lit,
  output logic             O_flash_start,
  output logic             O_busy,
  output logic [CYC_W-1:0] O_cycle_cnt
);

  logic             fs;
  logic             vs_act_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] dark_n_q, dark_n_d;
  logic [CNT_W-1:0] lit_n_q, lit_n_d;
  logic [23:0]      shadow_q, shadow_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       mode_q, mode_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             lit_q, lit_d;
  logic             flash_q, flash_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] dark_in, lit_in;

  vs_edge_det u_vs_edge_det (
    .I_pxl_clk (I_pxl_clk),
    .I_rst_n   (I_rst_n),
    .I_vs      (I_vs),
    .I_vs_pol  (I_vs_pol),
    .vs_act_d  (vs_act_d),
    .fs        (fs)
  );

  // A zero frame count is clamped to one so the down-counter can never underflow.
  assign dark_in = (I_dark_frames == '0) ? CNT_W'(1) : I_dark_frames;
  assign lit_in  = (I_lit_frames  == '0) ? CNT_W'(1) : I_lit_frames;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    dark_n_d = dark_n_q;
    lit_n_d  = lit_n_q;
    shadow_d = shadow_q;
    cyc_d    = cyc_q;
    mode_d   = mode_q;
    rgb_d    = rgb_q;
    lit_d    = lit_q;
    flash_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (I_enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!I_enable) begin
          state_d = ST_IDLE;
        end else if (fs) begin
          dark_n_d = dark_in;
          lit_n_d  = lit_in;
          shadow_d = {I_lit_r, I_lit_g, I_lit_b};
          phase_d  = dark_in - CNT_W'(1);
          state_d  = ST_DARK;
        end
      end
      ST_DARK: begin
        if (fs) begin
          if (!I_enable) begin
            state_d = ST_IDLE;
          end else if (phase_q == '0) begin
            phase_d = lit_n_q - CNT_W'(1);
            flash_d = 1'b1;
            state_d = ST_LIT;
          end else begin
            phase_d = phase_q - CNT_W'(1);
          end
        end
      end
      ST_LIT: begin
        if (fs) begin
          if (!I_enable) begin
            state_d = ST_IDLE;
          end else if (phase_q == '0) begin
            cyc_d    = cyc_q + CYC_W'(1);
            dark_n_d = dark_in;
            lit_n_d  = lit_in;
            shadow_d = {I_lit_r, I_lit_g, I_lit_b};
            phase_d  = dark_in - CNT_W'(1);
            state_d  = ST_DARK;
          end else begin
            phase_d = phase_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    unique case (state_d)
      ST_IDLE: begin
        mode_d = I_idle_mode;
        rgb_d  = COLOR_BLACK;
        lit_d  = 1'b0;
      end
      ST_ARM: ;
      ST_DARK: begin
        mode_d = MODE_SINGLE;
        rgb_d  = COLOR_BLACK;
        lit_d  = 1'b0;
      end
      ST_LIT: begin
        mode_d = MODE_SINGLE;
        rgb_d  = shadow_q;
        lit_d  = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      dark_n_q <= CNT_W'(1);
      lit_n_q  <= CNT_W'(1);
      shadow_q <= COLOR_BLACK;
      cyc_q    <= '0;
      mode_q   <= 3'b000;
      rgb_q    <= COLOR_BLACK;
      lit_q    <= 1'b0;
      flash_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dark_n_q <= dark_n_d;
      lit_n_q  <= lit_n_d;
      shadow_q <= shadow_d;
      cyc_q    <= cyc_d;
      mode_q   <= mode_d;
      rgb_q    <= rgb_d;
      lit_q    <= lit_d;
      flash_q  <= flash_d;
      busy_q   <= busy_d;
    end
  end

  assign O_mode        = mode_q;
  assign O_single_r    = rgb_q[23:16];
  assign O_single_g    = rgb_q[15:8];
  assign O_single_b    = rgb_q[7:0];
  assign O_lit         = lit_q;
  assign O_flash_start = flash_q;
  assign O_busy        = busy_q;
  assign O_cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// Directed bench for flash_sequencer: per-frame vector table plus hand-written reset,
// ARM-abort and counter-wrap sequences.
module tb_flash_sequencer;

  localparam logic [2:0] IDLE_MODE = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic        vs_pol;
  logic        en;
  logic [7:0]  dark_fr, lit_fr;
  logic [7:0]  lit_r;
  logic [7:0]  lit_g = 8'h11;
  logic [7:0]  lit_b = 8'h22;
  logic [2:0]  idle_mode = IDLE_MODE;

  logic [2:0]  mode;
  logic [7:0]  sr, sg, sb;
  logic        lit, flash, busy;
  logic [15:0] cyc;

  logic [2:0]  mode4;
  logic [7:0]  sr4, sg4, sb4;
  logic        lit4, flash4, busy4;
  logic [3:0]  cyc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flash_sequencer #(.CNT_W(8), .CYC_W(16)) dut (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_vs_pol(vs_pol), .I_enable(en),
    .I_dark_frames(dark_fr), .I_lit_frames(lit_fr),
    .I_lit_r(lit_r), .I_lit_g(lit_g), .I_lit_b(lit_b), .I_idle_mode(idle_mode),
    .O_mode(mode), .O_single_r(sr), .O_single_g(sg), .O_single_b(sb),
    .O_lit(lit), .O_flash_start(flash), .O_busy(busy), .O_cycle_cnt(cyc)
  );

  flash_sequencer #(.CNT_W(8), .CYC_W(4)) dut4 (
    .I_pxl_clk(clk), .I_rst_n(rst_n), .I_vs(vs), .I_vs_pol(vs_pol), .I_enable(en),
    .I_dark_frames(dark_fr), .I_lit_frames(lit_fr),
    .I_lit_r(lit_r), .I_lit_g(lit_g), .I_lit_b(lit_b), .I_idle_mode(idle_mode),
    .O_mode(mode4), .O_single_r(sr4), .O_single_g(sg4), .O_single_b(sb4),
    .O_lit(lit4), .O_flash_start(flash4), .O_busy(busy4), .O_cycle_cnt(cyc4)
  );

  typedef struct {
    string       name;
    logic [7:0]  dark;
    logic [7:0]  litn;
    logic [7:0]  r;
    logic        en;
    logic        e_lit;
    logic        e_flash;
    logic        e_busy;
    logic [2:0]  e_mode;
    logic [7:0]  e_r;
    logic [15:0] e_cyc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [7:0] dark, logic [7:0] litn, logic [7:0] r,
                              logic en, logic e_lit, logic e_flash, logic e_busy,
                              logic [2:0] e_mode, logic [7:0] e_r, logic [15:0] e_cyc);
    vec_t v;
    v.name = name; v.dark = dark; v.litn = litn; v.r = r; v.en = en;
    v.e_lit = e_lit; v.e_flash = e_flash; v.e_busy = e_busy;
    v.e_mode = e_mode; v.e_r = e_r; v.e_cyc = e_cyc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    vs    = ~vs_pol;
    en    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One frame: VS active for 2 clocks, inactive for 6; outputs sampled 2 cycles after the edge.
  task automatic run_row(input vec_t v);
    @(negedge clk);
    dark_fr = v.dark;
    lit_fr  = v.litn;
    lit_r   = v.r;
    en      = v.en;
    vs      = vs_pol;
    @(negedge clk);
    chk({v.name, ".flash_early"}, 32'(flash), 32'd0);
    @(negedge clk);
    chk({v.name, ".lit"},   32'(lit),   32'(v.e_lit));
    chk({v.name, ".flash"}, 32'(flash), 32'(v.e_flash));
    chk({v.name, ".busy"},  32'(busy),  32'(v.e_busy));
    chk({v.name, ".mode"},  32'(mode),  32'(v.e_mode));
    chk({v.name, ".r"},     32'(sr),    32'(v.e_r));
    chk({v.name, ".cyc"},   32'(cyc),   32'(v.e_cyc));
    vs = ~vs_pol;
    @(negedge clk);
    chk({v.name, ".flash_width"}, 32'(flash), 32'd0);
    repeat (4) @(negedge clk);
    chk({v.name, ".lit_held"}, 32'(lit), 32'(v.e_lit));
  endtask

  task automatic run_range(input int first, input int last);
    for (int i = first; i <= last; i++) run_row(vecs[i]);
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b1; vs_pol = 1'b0; en = 1'b0;
    dark_fr = 8'd1; lit_fr = 8'd1; lit_r = 8'h00;

    // dark=2 lit=1, VS active-low (rows 0..8)
    vecs.push_back(mk("t2f0", 2, 1, 8'hAA, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    vecs.push_back(mk("t2f1", 2, 1, 8'hAA, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    vecs.push_back(mk("t2f2", 2, 1, 8'hAA, 1, 1, 1, 1, 3'b011, 8'hAA, 0));
    vecs.push_back(mk("t2f3", 2, 1, 8'hAA, 1, 0, 0, 1, 3'b011, 8'h00, 1));
    vecs.push_back(mk("t2f4", 2, 1, 8'hAA, 1, 0, 0, 1, 3'b011, 8'h00, 1));
    vecs.push_back(mk("t2f5", 2, 1, 8'hAA, 1, 1, 1, 1, 3'b011, 8'hAA, 1));
    vecs.push_back(mk("t2f6", 2, 1, 8'hAA, 1, 0, 0, 1, 3'b011, 8'h00, 2));
    vecs.push_back(mk("t2f7", 2, 1, 8'hAA, 1, 0, 0, 1, 3'b011, 8'h00, 2));
    vecs.push_back(mk("t2f8", 2, 1, 8'hAA, 1, 1, 1, 1, 3'b011, 8'hAA, 2));
    // VS active-high, zero counts clamp to one (rows 9..13)
    vecs.push_back(mk("t3f0", 0, 0, 8'h5C, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    vecs.push_back(mk("t3f1", 0, 0, 8'h5C, 1, 1, 1, 1, 3'b011, 8'h5C, 0));
    vecs.push_back(mk("t3f2", 0, 0, 8'h5C, 1, 0, 0, 1, 3'b011, 8'h00, 1));
    vecs.push_back(mk("t3f3", 0, 0, 8'h5C, 1, 1, 1, 1, 3'b011, 8'h5C, 1));
    vecs.push_back(mk("t3f4", 0, 0, 8'h5C, 1, 0, 0, 1, 3'b011, 8'h00, 2));
    // mid-LIT colour change (rows 14..18)
    vecs.push_back(mk("t4f0", 1, 2, 8'hFF, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    vecs.push_back(mk("t4f1", 1, 2, 8'hFF, 1, 1, 1, 1, 3'b011, 8'hFF, 0));
    vecs.push_back(mk("t4f2", 1, 2, 8'h40, 1, 1, 0, 1, 3'b011, 8'hFF, 0));
    vecs.push_back(mk("t4f3", 1, 2, 8'h40, 1, 0, 0, 1, 3'b011, 8'h00, 1));
    vecs.push_back(mk("t4f4", 1, 2, 8'h40, 1, 1, 1, 1, 3'b011, 8'h40, 1));
    // disable coinciding with dark expiry (rows 19..21)
    vecs.push_back(mk("t5f0", 2, 1, 8'h77, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    vecs.push_back(mk("t5f1", 2, 1, 8'h77, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    vecs.push_back(mk("t5f2", 2, 1, 8'h77, 0, 0, 0, 0, IDLE_MODE, 8'h00, 0));

    do_reset();
    chk("rst.mode", 32'(mode), 32'(IDLE_MODE));
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cyc",  32'(cyc),  32'd0);

    run_range(0, 8);

    // async reset mid-LIT
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1.mode",  32'(mode),  32'd0);
    chk("t1.r",     32'(sr),    32'd0);
    chk("t1.lit",   32'(lit),   32'd0);
    chk("t1.flash", 32'(flash), 32'd0);
    chk("t1.busy",  32'(busy),  32'd0);
    chk("t1.cyc",   32'(cyc),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1.idle_mode", 32'(mode), 32'(IDLE_MODE));
    chk("t1.idle_busy", 32'(busy), 32'd0);

    // enable dropped in ARM returns to IDLE without any frame start
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("arm.busy", 32'(busy), 32'd1);
    chk("arm.mode_held", 32'(mode), 32'(IDLE_MODE));
    en = 1'b0;
    @(negedge clk);
    chk("arm.abort_busy", 32'(busy), 32'd0);

    vs_pol = 1'b1;
    do_reset();
    run_range(9, 13);

    vs_pol = 1'b0;
    do_reset();
    run_range(14, 18);
    chk("t4.g", 32'(sg), 32'h11);
    chk("t4.b", 32'(sb), 32'h22);

    do_reset();
    run_range(19, 21);

    // 17 dark+lit cycles: 4-bit counter wraps 15 -> 0 -> 1
    do_reset();
    run_row(mk("t6f0", 1, 1, 8'h33, 1, 0, 0, 1, 3'b011, 8'h00, 0));
    for (int k = 1; k <= 17; k++) begin
      run_row(mk("t6lit", 1, 1, 8'h33, 1, 1, 1, 1, 3'b011, 8'h33, 16'(k - 1)));
      run_row(mk("t6dark", 1, 1, 8'h33, 1, 0, 0, 1, 3'b011, 8'h00, 16'(k)));
      if (k >= 15) chk("t6.cyc4", 32'(cyc4), 32'(k % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
